// File: rtl/updown_counter_param_if.sv
// Control/status bundle for the parametrised up/down counter.
// The master drives the count controls and the slave returns the count and flags.
interface updown_counter_param_if #(
    parameter int WIDTH = 12
);
    logic             en;
    logic             up;
    logic             clr;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, clr, ld, ld_val,
        input  q, tc, ovf
    );

    modport slave (
        input  en, up, clr, ld, ld_val,
        output q, tc, ovf
    );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, clear, wrap/saturate bounds,
// optional enable edge detection, a terminal-count pulse and a sticky overflow flag.
module updown_counter_param #(
    parameter int WIDTH   = 12,
    parameter int MAX_VAL = 4095,
    parameter int SAT     = 0,
    parameter int EDGE_EN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    updown_counter_param_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             en_prev_q;
    logic             cnt_evt;

    assign cnt_evt = (EDGE_EN != 0) ? (bus.en & ~en_prev_q) : bus.en;

    // Bounds are checked against MAX_Q, so q never leaves 0..MAX_VAL.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (bus.clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (bus.ld) begin
            cnt_d = (bus.ld_val > MAX_Q) ? MAX_Q : bus.ld_val;
        end else if (cnt_evt) begin
            if (bus.up) begin
                if (cnt_q >= MAX_Q) begin
                    cnt_d = (SAT != 0) ? cnt_q : '0;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = (SAT != 0) ? cnt_q : MAX_Q;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
            en_prev_q <= bus.en;
        end
    end

    assign bus.q   = cnt_q;
    assign bus.tc  = tc_q;
    assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations (wrap, saturate, edge-enable)
// share one stimulus stream and are checked against directed constants and a reference model.
module tb_updown_counter_param;
    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_s, ld_s, en_s, up_s;
    logic [3:0] ldv_s;

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(4)) if0 ();
    updown_counter_param_if #(.WIDTH(4)) if1 ();
    updown_counter_param_if #(.WIDTH(4)) if2 ();

    assign if0.en = en_s;  assign if0.up = up_s;  assign if0.clr = clr_s;
    assign if0.ld = ld_s;  assign if0.ld_val = ldv_s;
    assign if1.en = en_s;  assign if1.up = up_s;  assign if1.clr = clr_s;
    assign if1.ld = ld_s;  assign if1.ld_val = ldv_s;
    assign if2.en = en_s;  assign if2.up = up_s;  assign if2.clr = clr_s;
    assign if2.ld = ld_s;  assign if2.ld_val = ldv_s;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(MAXV), .SAT(0), .EDGE_EN(0)) d0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    updown_counter_param #(.WIDTH(4), .MAX_VAL(MAXV), .SAT(1), .EDGE_EN(0)) d1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    updown_counter_param #(.WIDTH(4), .MAX_VAL(MAXV), .SAT(0), .EDGE_EN(1)) d2 (
        .clk(clk), .rst(rst), .bus(if2.slave));

    int tests = 0;
    int fails = 0;

    // Reference model state per configuration
    int mq[3], mtc[3], movf[3], mprev[3];
    int msat[3]  = '{0, 1, 0};
    int medge[3] = '{0, 0, 1};

    typedef struct {
        bit clr; bit ld; int ldv; bit en; bit up;
        int q; int tc; int ovf;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [31:0] dq(input int i);
        case (i)
            0: return 32'(if0.q);
            1: return 32'(if1.q);
            default: return 32'(if2.q);
        endcase
    endfunction

    function automatic logic [31:0] dtc(input int i);
        case (i)
            0: return 32'(if0.tc);
            1: return 32'(if1.tc);
            default: return 32'(if2.tc);
        endcase
    endfunction

    function automatic logic [31:0] dovf(input int i);
        case (i)
            0: return 32'(if0.ovf);
            1: return 32'(if1.ovf);
            default: return 32'(if2.ovf);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0; mtc[i] = 0; movf[i] = 0; mprev[i] = 0;
        end
    endtask

    // Applies the counting rules directly to the integer count of each configuration.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit evt;
                evt = (medge[i] != 0) ? (en_s && mprev[i] == 0) : en_s;
                mtc[i] = 0;
                if (clr_s) begin
                    mq[i] = 0; movf[i] = 0;
                end else if (ld_s) begin
                    mq[i] = (int'(ldv_s) > MAXV) ? MAXV : int'(ldv_s);
                end else if (evt) begin
                    if (up_s && mq[i] == MAXV) begin
                        mtc[i] = 1; movf[i] = 1;
                        if (msat[i] == 0) mq[i] = 0;
                    end else if (!up_s && mq[i] == 0) begin
                        mtc[i] = 1; movf[i] = 1;
                        if (msat[i] == 0) mq[i] = MAXV;
                    end else begin
                        mq[i] = up_s ? mq[i] + 1 : mq[i] - 1;
                    end
                end
                mprev[i] = en_s ? 1 : 0;
            end
        end
    endtask

    task automatic cycle(input bit c, input bit l, input int v, input bit e, input bit u);
        clr_s = c; ld_s = l; ldv_s = 4'(v); en_s = e; up_s = u;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_model(input int i);
        chk($sformatf("rand_d%0d_q", i), dq(i), 32'(mq[i]));
        chk($sformatf("rand_d%0d_tc", i), dtc(i), 32'(mtc[i]));
        chk($sformatf("rand_d%0d_ovf", i), dovf(i), 32'(movf[i]));
    endtask

    initial begin
        int edge_pat[7];
        int edge_exp[7];
        edge_pat = '{0, 1, 1, 1, 0, 1, 0};
        edge_exp = '{0, 1, 1, 1, 1, 2, 2};

        rst = 1'b0; clr_s = 0; ld_s = 0; ldv_s = 0; en_s = 0; up_s = 0;
        model_reset();

        // Held in reset with counting requested
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 1);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rst_d%0d_q", i), dq(i), 0);
                chk($sformatf("rst_d%0d_tc", i), dtc(i), 0);
                chk($sformatf("rst_d%0d_ovf", i), dovf(i), 0);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 1);
            chk($sformatf("release_d0_q%0d", k), dq(0), 32'(k + 1));
            chk($sformatf("release_edge_q%0d", k), dq(2), 1);
        end

        // Wrap-mode vectors, starting from q=3
        tbl[0]  = '{0, 1, 8,  0, 1, 8, 0, 0};
        tbl[1]  = '{0, 0, 0,  1, 1, 9, 0, 0};
        tbl[2]  = '{0, 0, 0,  1, 1, 0, 1, 1};
        tbl[3]  = '{0, 0, 0,  1, 1, 1, 0, 1};
        tbl[4]  = '{1, 0, 0,  0, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0,  1, 0, 9, 1, 1};
        tbl[6]  = '{0, 1, 5,  0, 1, 5, 0, 1};
        tbl[7]  = '{1, 1, 7,  1, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 7,  1, 1, 7, 0, 0};
        tbl[9]  = '{0, 1, 15, 0, 1, 9, 0, 0};
        tbl[10] = '{0, 0, 0,  1, 0, 8, 0, 0};
        tbl[11] = '{0, 0, 0,  0, 1, 8, 0, 0};
        for (int k = 0; k < 12; k++) begin
            cycle(tbl[k].clr, tbl[k].ld, tbl[k].ldv, tbl[k].en, tbl[k].up);
            chk($sformatf("vec%0d_q", k), dq(0), 32'(tbl[k].q));
            chk($sformatf("vec%0d_tc", k), dtc(0), 32'(tbl[k].tc));
            chk($sformatf("vec%0d_ovf", k), dovf(0), 32'(tbl[k].ovf));
        end

        // Saturation at the top bound
        cycle(0, 1, 9, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1, 1);
            chk($sformatf("sat_q%0d", k), dq(1), 9);
            chk($sformatf("sat_tc%0d", k), dtc(1), 1);
        end
        cycle(0, 0, 0, 1, 0);
        chk("sat_down_q", dq(1), 8);
        chk("sat_down_tc", dtc(1), 0);
        chk("sat_ovf_sticky", dovf(1), 1);

        // Edge-triggered enable
        cycle(1, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            cycle(0, 0, 0, edge_pat[k] != 0, 1);
            chk($sformatf("edge_q%0d", k), dq(2), 32'(edge_exp[k]));
        end

        // Asynchronous reset between clock edges
        cycle(0, 1, 9, 0, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 1, 5, 0, 1);
        cycle(0, 0, 0, 1, 1);
        chk("async_pre_q", dq(0), 6);
        chk("async_pre_ovf", dovf(0), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_q", dq(0), 0);
        chk("async_ovf", dovf(0), 0);
        chk("async_tc", dtc(0), 0);
        chk("async_d1_q", dq(1), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 0, 0, 1, 1);
        chk("resume_q1", dq(0), 1);
        cycle(0, 0, 0, 1, 1);
        chk("resume_q2", dq(0), 2);

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            bit c, l, e, u;
            c = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 2) != 0);
            cycle(c, l, int'($urandom_range(0, 15)), e, u);
            for (int i = 0; i < 3; i++) chk_model(i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
